egress_voq: RTL and testbench

Per-egress-port virtual output queue. It sits directly downstream of the crossbar and receives one bit of the crossbar's write-request vector plus the matching frame start pointer. It buffers frame start pointers (buffer-memory addresses) in arrival order. It presents them to the egress scheduler through a valid/ready dequeue handshake, and drops frames whose pointer cannot be stored. One instance exists per port; instances are replicated NUM_PORTS times at switch top level.

---
 rtl/egress_voq.sv | 96 +++++++++
 tb/tb_egress_voq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/egress_voq.sv
// Per-egress-port virtual output queue: FIFO of frame start pointers with a FWFT dequeue.
// The optional saturating drop counter is enabled by defining VOQ_DROP_STATS_EN.
module egress_voq #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 12,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_req_i,
    input  logic [ADDR_W-1:0]          start_ptr_i,
    input  logic                       flush_i,
    input  logic                       deq_ready_i,
    output logic                       deq_valid_o,
    output logic [ADDR_W-1:0]          deq_ptr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic                       drop_o
`ifdef VOQ_DROP_STATS_EN
    ,
    output logic [15:0]                drop_count_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [ADDR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_nxt, rd_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             full_q, afull_q, drop_q;
    logic             pop, push_ok, drop_nxt;

    always_comb begin
        pop      = (count_q != '0) && deq_ready_i && !flush_i;
        // A full queue still accepts a write when the same edge frees the head slot.
        push_ok  = write_req_i && !flush_i && ((count_q != FULL_CNT) || pop);
        drop_nxt = write_req_i && !push_ok;
        wr_nxt   = wr_ptr + PTR_W'(push_ok);
        rd_nxt   = flush_i ? wr_ptr : (rd_ptr + PTR_W'(pop));
        count_nxt = CNT_W'(wr_nxt - rd_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            count_q <= count_nxt;
            full_q  <= (count_nxt == FULL_CNT);
            afull_q <= (count_nxt >= AFULL_CNT);
            drop_q  <= drop_nxt;
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr[IDX_W-1:0]] <= start_ptr_i;
        end
    end

`ifdef VOQ_DROP_STATS_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_nxt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count_o = drop_cnt_q;
`endif

    assign deq_valid_o   = (count_q != '0);
    assign deq_ptr_o     = mem[rd_ptr[IDX_W-1:0]];
    assign count_o       = count_q;
    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign drop_o        = drop_q;

endmodule

// File: tb/tb_egress_voq.sv
// Scoreboard bench for egress_voq: stimulus pushes expected pointers, a negedge monitor checks pops.
module tb_egress_voq;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 12;
    localparam int AF     = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write_req_i = 1'b0;
    logic [ADDR_W-1:0] start_ptr_i = '0;
    logic              flush_i = 1'b0;
    logic              deq_ready_i = 1'b0;
    logic              deq_valid_o;
    logic [ADDR_W-1:0] deq_ptr_o;
    logic [4:0]        count_o;
    logic              full_o, almost_full_o, drop_o;
`ifdef VOQ_DROP_STATS_EN
    logic [15:0]       drop_count_o;
`endif

    egress_voq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_THRESH(AF)) dut (
        .clk           (clk),
        .rst           (rst),
        .write_req_i   (write_req_i),
        .start_ptr_i   (start_ptr_i),
        .flush_i       (flush_i),
        .deq_ready_i   (deq_ready_i),
        .deq_valid_o   (deq_valid_o),
        .deq_ptr_o     (deq_ptr_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .drop_o        (drop_o)
`ifdef VOQ_DROP_STATS_EN
        ,
        .drop_count_o  (drop_count_o)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [ADDR_W-1:0] exp_q[$];
    int  m_cnt   = 0;
    bit  m_drop  = 0;
    int  m_dcnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever these conditions hold now.
    always @(negedge clk) begin
        if (!rst && !flush_i && deq_valid_o && deq_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL deq_unexpected: got %0h expected no entry", deq_ptr_o);
            end else begin
                chk("deq_ptr", 32'(deq_ptr_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state(input string tag);
        chk({tag, ".count"},  32'(count_o),       32'(m_cnt));
        chk({tag, ".valid"},  32'(deq_valid_o),   32'(m_cnt != 0));
        chk({tag, ".full"},   32'(full_o),        32'(m_cnt == DEPTH));
        chk({tag, ".afull"},  32'(almost_full_o), 32'(m_cnt >= AF));
        chk({tag, ".drop"},   32'(drop_o),        32'(m_drop));
        if (m_cnt != 0 && exp_q.size() != 0)
            chk({tag, ".head"}, 32'(deq_ptr_o), 32'(exp_q[0]));
`ifdef VOQ_DROP_STATS_EN
        chk({tag, ".dcnt"},   32'(drop_count_o),  32'(m_dcnt));
`endif
    endtask

    task automatic cycle(input bit wr, input logic [ADDR_W-1:0] p, input bit rdy, input bit fl,
                         input string tag);
        bit pop, acc;
        write_req_i = wr;
        start_ptr_i = p;
        deq_ready_i = rdy;
        flush_i     = fl;
        pop = (m_cnt != 0) && rdy && !fl;
        acc = wr && !fl && (m_cnt < DEPTH || pop);
        if (fl) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt - int'(pop);
        end
        if (acc) begin
            exp_q.push_back(p);
            m_cnt++;
        end
        m_drop = wr && !acc;
        if (m_drop && m_dcnt < 16'hFFFF) m_dcnt++;
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        write_req_i = 1'b1;
        start_ptr_i = 12'h7EE;
        deq_ready_i = 1'b1;
        flush_i     = 1'b0;
        exp_q.delete();
        m_cnt = 0; m_drop = 0; m_dcnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        write_req_i = 1'b0;
        deq_ready_i = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset");

        cycle(1, 12'h010, 0, 0, "push1");
        cycle(0, 12'h000, 1, 0, "pop1");
        cycle(0, 12'h000, 1, 0, "pop_empty");

        for (int i = 0; i < 16; i++)
            cycle(1, 12'(12'h100 + i), 0, 0, "fill");
        cycle(1, 12'h1FF, 0, 0, "overflow");
        cycle(0, 12'h000, 0, 0, "drop_clear");

        cycle(1, 12'h2AA, 1, 0, "full_pushpop");
        for (int i = 0; i < 17; i++)
            cycle(0, 12'h000, 1, 0, "drain");

        for (int i = 0; i < 40; i++)
            cycle((i % 3) != 2, 12'(12'h300 + i), (i % 4) < 2, 0, "mix");
        for (int i = 0; i < 20; i++)
            cycle(0, 12'h000, 1, 0, "mix_drain");

        for (int i = 0; i < 5; i++)
            cycle(1, 12'(12'h050 + i), 0, 0, "pre_flush");
        cycle(1, 12'h055, 1, 1, "flush");
        cycle(1, 12'h066, 0, 0, "post_flush_push");
        cycle(0, 12'h000, 1, 0, "post_flush_pop");

        for (int i = 0; i < 7; i++)
            cycle(1, 12'(12'h070 + i), 0, 0, "pre_reset");
        do_reset("mid_reset");

        for (int i = 0; i < 16; i++)
            cycle(1, 12'(12'h400 + i), 0, 0, "refill");
        for (int i = 0; i < 3; i++)
            cycle(1, 12'h4FF, 0, 0, "stat_drop");
        cycle(0, 12'h000, 0, 0, "stat_idle");
        for (int i = 0; i < 17; i++)
            cycle(0, 12'h000, 1, 0, "final_drain");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
